iter_alu: RTL and testbench
===========================

// Module: iter_alu
// PURPOSE
//   Parametrised, registered successor to the EXE-stage combinational ALU.
//   Keeps the existing EXE_CMD encodings for single-cycle ops and adds iterative unsigned multiply, divide and remainder.
//   Uses a start/busy/done handshake so the EXE stage can stall on multi-cycle ops.
//   Adds true arithmetic right shift, shift-amount masking, and zero / div-by-zero flags.
// PARAMETERS
//   WIDTH    32              operand/result width; >=4, power of two
//   SHAMT_W  $clog2(WIDTH)   shift-amount bits taken from val2[SHAMT_W-1:0]
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset
//   start       in   1          request; accepted only when busy==0
//   exe_cmd     in   4          operation; sampled with start
//   val1        in   WIDTH      operand A; sampled with start
//   val2        in   WIDTH      operand B; sampled with start
//   busy        out  1          high while a multi-cycle op iterates
//   done        out  1          one-cycle pulse: result/flags valid
//   alu_result  out  WIDTH      result (MUL: low half)
//   hi_result   out  WIDTH      MUL high half; 0 for all other ops
//   zero        out  1          alu_result==0; updated with done
//   div_by_zero out  1          DIVU/REMU with val2==0; updated with done
// BEHAVIOUR
//   Opcodes:
//     0 ADD, 2 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR  (ADD/SUB wrap mod 2^WIDTH, no overflow flag)
//     8 SLL, 9 SRA (sign-fill), 10 SRL, shift by val2[SHAMT_W-1:0]
//     11 MULU, 12 DIVU (quotient), 13 REMU (remainder)
//     1, 3, 14, 15: illegal -> result 0, done still pulses
//   FSM states IDLE, ITER, DONE:
//     IDLE/DONE + start, single-cycle op -> DONE; result registered; done=1 next cycle (latency 1)
//     IDLE/DONE + start, op 11-13 -> ITER; operands latched; counter=WIDTH-1; busy=1 from the next cycle
//     ITER: one shift-add (MULU) or one restoring step (DIVU/REMU) per cycle
//     ITER: counter==0 -> DONE; total latency WIDTH+1 cycles from start to done
//     DONE: done=1 for exactly one cycle -> IDLE, or accepts a new start (back-to-back allowed)
//   Handshake:
//     start while busy=1 is ignored; no queueing
//     exe_cmd/val1/val2 may change freely after acceptance
//   Outputs:
//     alu_result, hi_result, zero, div_by_zero hold their last values until the next done
//     done is the only pulse
//   Divide by zero (no iterations are skipped; latency unchanged):
//     DIVU -> all ones, REMU -> val1, div_by_zero=1
//   Reset (any time, including mid-ITER):
//     state IDLE; busy=0, done=0, alu_result=0, hi_result=0, zero=0, div_by_zero=0
//     partial product/quotient discarded
//   start at the same edge as rst deassertion is ignored
//   Internal accumulators are 2*WIDTH bits; no internal truncation before final selection
// TESTING (WIDTH=32)
//   rst mid-MULU (cycle 10 of busy) -> busy=0, done=0, alu_result=0
//     then a new ADD 1+1 -> done at +1, result 2
//   ADD 0xFFFFFFFF+1 -> done at +1, alu_result=0, zero=1
//     then back-to-back SUB 5-7 issued in the done cycle -> 0xFFFFFFFE
//   SRA 0x80000000 by 31 -> 0xFFFFFFFF
//     SRL same -> 0x00000001
//     SLL 1 by val2=0x21 -> 0x00000002 (masked amount 1)
//   MULU 0xFFFFFFFF*0xFFFFFFFF
//     -> busy for 32 cycles, done at +33, hi=0xFFFFFFFE, lo=0x00000001
//     extra start pulses during busy are ignored
//   DIVU 100/7 -> 14; REMU 100/7 -> 2
//   DIVU 9/0 -> 0xFFFFFFFF, div_by_zero=1; REMU 9/0 -> 9
//   Illegal cmd 3 -> done at +1, alu_result=0, hi_result=0, zero=1

Source files
------------

// File: rtl/iter_alu_if.sv
// Handshake and operand/result bundle between the EXE stage and iter_alu.
interface iter_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [3:0]       exe_cmd;
   logic [WIDTH-1:0] val1;
   logic [WIDTH-1:0] val2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] hi_result;
   logic             zero;
   logic             div_by_zero;

   // Requester side: issues commands, observes status and results.
   modport master (
      output start, exe_cmd, val1, val2,
      input  busy, done, alu_result, hi_result, zero, div_by_zero
   );

   // ALU side.
   modport slave (
      input  start, exe_cmd, val1, val2,
      output busy, done, alu_result, hi_result, zero, div_by_zero
   );
endinterface

// File: rtl/iter_alu.sv
// Registered EXE-stage ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply (shift-add) and divide/remainder (restoring), one bit per cycle.
module iter_alu #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst,
   iter_alu_if.slave bus
);
   localparam int unsigned DW = 2 * WIDTH;

   localparam logic [3:0] CMD_ADD  = 4'd0;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_AND  = 4'd4;
   localparam logic [3:0] CMD_OR   = 4'd5;
   localparam logic [3:0] CMD_NOR  = 4'd6;
   localparam logic [3:0] CMD_XOR  = 4'd7;
   localparam logic [3:0] CMD_SLL  = 4'd8;
   localparam logic [3:0] CMD_SRA  = 4'd9;
   localparam logic [3:0] CMD_SRL  = 4'd10;
   localparam logic [3:0] CMD_MULU = 4'd11;
   localparam logic [3:0] CMD_DIVU = 4'd12;
   localparam logic [3:0] CMD_REMU = 4'd13;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t             state;
   logic [SHAMT_W-1:0] cnt;
   logic [3:0]         op;
   logic [DW-1:0]      acc;     // MULU: partial product; DIVU/REMU: {remainder, quotient}
   logic [DW-1:0]      mcand;   // MULU: multiplicand, shifted left each step
   logic [WIDTH-1:0]   opb;     // MULU: multiplier (shifts right); DIVU/REMU: divisor

   logic [SHAMT_W-1:0] sh_c;
   logic               multi_c;
   logic [WIDTH-1:0]   fast_c;

   // Single-cycle result straight from the request operands.
   always_comb begin
      sh_c    = bus.val2[SHAMT_W-1:0];
      multi_c = (bus.exe_cmd == CMD_MULU) || (bus.exe_cmd == CMD_DIVU) ||
                (bus.exe_cmd == CMD_REMU);
      fast_c  = '0;
      case (bus.exe_cmd)
         CMD_ADD: fast_c = bus.val1 + bus.val2;
         CMD_SUB: fast_c = bus.val1 - bus.val2;
         CMD_AND: fast_c = bus.val1 & bus.val2;
         CMD_OR:  fast_c = bus.val1 | bus.val2;
         CMD_NOR: fast_c = ~(bus.val1 | bus.val2);
         CMD_XOR: fast_c = bus.val1 ^ bus.val2;
         CMD_SLL: fast_c = bus.val1 << sh_c;
         CMD_SRA: fast_c = WIDTH'($signed(bus.val1) >>> sh_c);
         CMD_SRL: fast_c = bus.val1 >> sh_c;
         default: fast_c = '0;
      endcase
   end

   logic [DW-1:0]    mul_nxt_c;
   logic [WIDTH:0]   dtop_c;
   logic [WIDTH-1:0] ddiff_c;
   logic [DW-1:0]    div_nxt_c;
   logic [DW-1:0]    step_c;
   logic [WIDTH-1:0] res_lo_c;
   logic [WIDTH-1:0] res_hi_c;

   // One iteration step and final result selection from the stepped accumulator.
   always_comb begin
      mul_nxt_c = acc + (opb[0] ? mcand : '0);
      // Shifted-left remainder needs WIDTH+1 bits before the trial subtract.
      dtop_c    = acc[DW-1:WIDTH-1];
      ddiff_c   = dtop_c[WIDTH-1:0] - opb;
      if (dtop_c >= {1'b0, opb}) begin
         div_nxt_c = {ddiff_c, acc[WIDTH-2:0], 1'b1};
      end else begin
         div_nxt_c = {acc[DW-2:0], 1'b0};
      end
      step_c   = (op == CMD_MULU) ? mul_nxt_c : div_nxt_c;
      res_lo_c = (op == CMD_REMU) ? step_c[DW-1:WIDTH] : step_c[WIDTH-1:0];
      res_hi_c = (op == CMD_MULU) ? step_c[DW-1:WIDTH] : '0;
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         op              <= '0;
         acc             <= '0;
         mcand           <= '0;
         opb             <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.alu_result  <= '0;
         bus.hi_result   <= '0;
         bus.zero        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (bus.start) begin
                  op <= bus.exe_cmd;
                  if (multi_c) begin
                     state    <= ITER;
                     bus.busy <= 1'b1;
                     cnt      <= SHAMT_W'(WIDTH - 1);
                     opb      <= bus.val2;
                     if (bus.exe_cmd == CMD_MULU) begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, bus.val1};
                     end else begin
                        acc   <= {{WIDTH{1'b0}}, bus.val1};
                        mcand <= '0;
                     end
                  end else begin
                     state           <= DONE;
                     bus.done        <= 1'b1;
                     bus.alu_result  <= fast_c;
                     bus.hi_result   <= '0;
                     bus.zero        <= (fast_c == '0);
                     bus.div_by_zero <= 1'b0;
                  end
               end
            end
            ITER: begin
               acc   <= step_c;
               mcand <= mcand << 1;
               if (op == CMD_MULU) begin
                  opb <= opb >> 1;
               end
               cnt <= cnt - SHAMT_W'(1);
               if (cnt == '0) begin
                  state           <= DONE;
                  bus.busy        <= 1'b0;
                  bus.done        <= 1'b1;
                  bus.alu_result  <= res_lo_c;
                  bus.hi_result   <= res_hi_c;
                  bus.zero        <= (res_lo_c == '0);
                  // The divisor register is not shifted for DIVU/REMU.
                  bus.div_by_zero <= (op != CMD_MULU) && (opb == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: reference model tracks expected outputs per cycle,
// directed vectors pin the model with hand-computed literals.
module tb_iter_alu;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   iter_alu_if #(.WIDTH(W)) bus_i ();

   iter_alu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int issue_cyc = 0;

   // Model state: cycle on which done is due, busy window, visible and pending results.
   int m_due   = -1;
   int b_start = -1;
   int b_end   = -2;
   logic [W-1:0] cur_lo = '0, cur_hi = '0, nxt_lo = '0, nxt_hi = '0;
   logic cur_zero = 1'b0, cur_dbz = 1'b0, nxt_dbz = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Returns {div_by_zero, hi, lo} from the arithmetic definition of each opcode.
   function automatic logic [2*W:0] ref_alu(input logic [3:0] cmd, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [2*W-1:0] p;
      logic [W-1:0]   lo, hi, ones;
      logic [4:0]     s;
      logic           dz;
      lo = '0; hi = '0; dz = 1'b0; ones = '1; s = b[4:0]; p = '0;
      case (cmd)
         4'd0:  lo = a + b;
         4'd2:  lo = a - b;
         4'd4:  lo = a & b;
         4'd5:  lo = a | b;
         4'd6:  lo = ~(a | b);
         4'd7:  lo = a ^ b;
         4'd8:  lo = a << s;
         4'd9:  lo = (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
         4'd10: lo = a >> s;
         4'd11: begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            hi = p[2*W-1:W];
            lo = p[W-1:0];
         end
         4'd12: if (b == '0) begin lo = ones; dz = 1'b1; end else lo = a / b;
         4'd13: if (b == '0) begin lo = a;    dz = 1'b1; end else lo = a % b;
         default: lo = '0;
      endcase
      return {dz, hi, lo};
   endfunction

   // Model update at each rising edge.
   always @(posedge clk) begin : model
      logic was_busy;
      was_busy = (cyc >= b_start) && (cyc <= b_end);
      cyc = cyc + 1;
      if (rst) begin
         m_due = -1; b_start = -1; b_end = -2;
         cur_lo = '0; cur_hi = '0; cur_zero = 1'b0; cur_dbz = 1'b0;
      end else begin
         if (bus_i.start && !was_busy) begin
            {nxt_dbz, nxt_hi, nxt_lo} = ref_alu(bus_i.exe_cmd, bus_i.val1, bus_i.val2);
            if (bus_i.exe_cmd inside {4'd11, 4'd12, 4'd13}) begin
               b_start = cyc;
               b_end   = cyc + W - 1;
               m_due   = cyc + W;
            end else begin
               m_due = cyc;
            end
         end
         if (cyc == m_due) begin
            cur_lo = nxt_lo; cur_hi = nxt_hi; cur_dbz = nxt_dbz;
            cur_zero = (nxt_lo == '0);
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_busy", W'(bus_i.busy), '0);
         check("rst_done", W'(bus_i.done), '0);
         check("rst_alu",  bus_i.alu_result, '0);
         check("rst_hi",   bus_i.hi_result, '0);
         check("rst_zero", W'(bus_i.zero), '0);
         check("rst_dbz",  W'(bus_i.div_by_zero), '0);
      end else begin
         check("done",        W'(bus_i.done), W'(cyc == m_due));
         check("busy",        W'(bus_i.busy), W'((cyc >= b_start) && (cyc <= b_end)));
         check("alu_result",  bus_i.alu_result, cur_lo);
         check("hi_result",   bus_i.hi_result, cur_hi);
         check("zero",        W'(bus_i.zero), W'(cur_zero));
         check("div_by_zero", W'(bus_i.div_by_zero), W'(cur_dbz));
      end
   end

   // Present a request for one cycle, then scramble the inputs.
   task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
      bus_i.exe_cmd = cmd;
      bus_i.val1    = a;
      bus_i.val2    = b;
      bus_i.start   = 1'b1;
      issue_cyc     = cyc;
      @(posedge clk); #1;
      bus_i.start   = 1'b0;
      bus_i.exe_cmd = 4'($urandom);
      bus_i.val1    = $urandom;
      bus_i.val2    = $urandom;
   endtask

   // Wait for done (bounded), optionally pulsing start while busy, then check literals.
   task automatic wait_lit(input string name, input int lat, input int nbusy,
                           input logic [W-1:0] lo, input logic [W-1:0] hi,
                           input logic z, input logic dz, input int pulses);
      int nb;
      int left;
      bit got;
      nb = 0; left = pulses; got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if (bus_i.done) begin
            got = 1'b1;
         end else begin
            if (bus_i.busy) nb++;
            if (left > 0 && bus_i.busy) begin
               bus_i.start   = 1'b1;
               bus_i.exe_cmd = 4'd0;
               left--;
            end else begin
               bus_i.start = 1'b0;
            end
         end
      end
      bus_i.start = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: no done within 60 cycles", name);
      end else begin
         check({name, "_latency"}, W'(cyc - issue_cyc), W'(lat));
         check({name, "_busycycles"}, W'(nb), W'(nbusy));
         check({name, "_lo"}, bus_i.alu_result, lo);
         check({name, "_hi"}, bus_i.hi_result, hi);
         check({name, "_zero"}, W'(bus_i.zero), W'(z));
         check({name, "_dbz"}, W'(bus_i.div_by_zero), W'(dz));
      end
   endtask

   // Wait for done with a bound; values are checked by the per-cycle compare.
   task automatic wait_done(input string name);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if (bus_i.done) got = 1'b1;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: no done within 60 cycles", name);
      end
   endtask

   typedef struct {
      logic [3:0]   cmd;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   vec_t vecs [12];

   initial begin
      bus_i.start = 1'b0; bus_i.exe_cmd = '0; bus_i.val1 = '0; bus_i.val2 = '0;
      vecs[0]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00};
      vecs[1]  = '{4'd5,  32'h0F0F_0000, 32'h0000_00FF};
      vecs[2]  = '{4'd6,  32'h0000_0000, 32'h0000_0000};
      vecs[3]  = '{4'd7,  32'hAAAA_5555, 32'hFFFF_FFFF};
      vecs[4]  = '{4'd11, 32'h0001_0000, 32'h0001_0000};
      vecs[5]  = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[6]  = '{4'd13, 32'h0000_0005, 32'h0000_0009};
      vecs[7]  = '{4'd14, 32'h1234_5678, 32'h1111_1111};
      vecs[8]  = '{4'd10, 32'h8765_4321, 32'h0000_0020};
      vecs[9]  = '{4'd8,  32'h0000_0003, 32'h0000_001F};
      vecs[10] = '{4'd9,  32'h7FFF_FFF0, 32'h0000_0004};
      vecs[11] = '{4'd12, 32'hDEAD_BEEF, 32'h0000_1234};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Start held while reset is high is dropped.
      @(posedge clk); #1;
      rst = 1'b1;
      bus_i.start = 1'b1; bus_i.exe_cmd = 4'd0; bus_i.val1 = 32'd1; bus_i.val2 = 32'd1;
      @(posedge clk); #1;
      rst = 1'b0; bus_i.start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("start_in_reset_done", W'(bus_i.done), '0);
      end

      // Shifts with sign fill and amount masking.
      issue(4'd9, 32'h8000_0000, 32'd31);
      wait_lit("sra", 1, 0, 32'hFFFF_FFFF, '0, 1'b0, 1'b0, 0);
      issue(4'd10, 32'h8000_0000, 32'd31);
      wait_lit("srl", 1, 0, 32'h0000_0001, '0, 1'b0, 1'b0, 0);
      issue(4'd8, 32'h0000_0001, 32'h0000_0021);
      wait_lit("sll", 1, 0, 32'h0000_0002, '0, 1'b0, 1'b0, 0);

      // Reset during the tenth busy cycle of a multiply.
      issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", W'(bus_i.busy), '0);
      check("midrst_done", W'(bus_i.done), '0);
      check("midrst_alu", bus_i.alu_result, '0);
      @(posedge clk); #1 rst = 1'b0;
      issue(4'd0, 32'd1, 32'd1);
      wait_lit("add_after_rst", 1, 0, 32'd2, '0, 1'b0, 1'b0, 0);

      // Wrapping add, then a subtract issued in its done cycle.
      issue(4'd0, 32'hFFFF_FFFF, 32'd1);
      wait_lit("add_wrap", 1, 0, 32'd0, '0, 1'b1, 1'b0, 0);
      issue(4'd2, 32'd5, 32'd7);
      wait_lit("sub_b2b", 1, 0, 32'hFFFF_FFFE, '0, 1'b0, 1'b0, 0);

      // Full-range multiply with ignored start pulses while busy.
      issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_lit("mulu_max", 33, 32, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);

      // Illegal opcode clears the high half left by the multiply.
      issue(4'd3, 32'h1234_5678, 32'h1111_1111);
      wait_lit("illegal3", 1, 0, '0, '0, 1'b1, 1'b0, 0);

      issue(4'd12, 32'd100, 32'd7);
      wait_lit("divu", 33, 32, 32'd14, '0, 1'b0, 1'b0, 0);
      issue(4'd13, 32'd100, 32'd7);
      wait_lit("remu", 33, 32, 32'd2, '0, 1'b0, 1'b0, 0);
      issue(4'd12, 32'd9, 32'd0);
      wait_lit("divu_by0", 33, 32, 32'hFFFF_FFFF, '0, 1'b0, 1'b1, 0);
      issue(4'd13, 32'd9, 32'd0);
      wait_lit("remu_by0", 33, 32, 32'd9, '0, 1'b0, 1'b1, 0);

      // Further patterns checked against the model only.
      foreach (vecs[i]) begin
         issue(vecs[i].cmd, vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
